// File: rtl/mips16_mem_pkg.sv
// Shared definitions for the mips16 memory-side blocks.
// State encoding and default memory depth.
package mips16_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  localparam int MEM_DEPTH_DEFAULT = 513;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, one-cycle memory access,
// response held until the pipeline consumes it.
module load_store_unit
  import mips16_mem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int DATA_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              Rm,
  output logic              Wm,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] RegVal,
  input  logic [DATA_W-1:0] Data_out,
  output logic [DATA_W-1:0] access_count
);

  localparam logic [DATA_W:0] DEPTH_LIM =
    (DATA_W+1)'(MEM_DEPTH);

  lsu_state_t state_q, state_d;

  logic              rm_q, rm_d;
  logic              wm_q, wm_d;
  logic [DATA_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] regval_q, regval_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] access_count_q, access_count_d;

  logic in_range;

  assign in_range = {1'b0, req_addr} < DEPTH_LIM;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = in_range ? ACCESS : RESP;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rm/Wm are registered so they are glitch-free for exactly the ACCESS cycle.
  always_comb begin
    rm_d           = 1'b0;
    wm_d           = 1'b0;
    address_d      = address_q;
    regval_d       = regval_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    resp_err_d     = resp_err_q;
    access_count_d = access_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (in_range) begin
            rm_d      = ~req_we;
            wm_d      = req_we;
            address_d = req_addr;
            regval_d  = req_wdata;
          end else begin
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        resp_valid_d   = 1'b1;
        resp_err_d     = 1'b0;
        resp_data_d    = wm_q ? '0 : Data_out;
        access_count_d = access_count_q + 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rm_q           <= 1'b0;
      wm_q           <= 1'b0;
      address_q      <= '0;
      regval_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_err_q     <= 1'b0;
      access_count_q <= '0;
    end else begin
      rm_q           <= rm_d;
      wm_q           <= wm_d;
      address_q      <= address_d;
      regval_q       <= regval_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
      access_count_q <= access_count_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_err     = resp_err_q;
  assign Rm           = rm_q;
  assign Wm           = wm_q;
  assign address      = address_q;
  assign RegVal       = regval_q;
  assign access_count = access_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model plus
// directed scenarios with literal expectations.
module tb_load_store_unit;

  localparam int DEPTH = 513;
  localparam int W     = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [W-1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic         Rm;
  logic         Wm;
  logic [W-1:0] address;
  logic [W-1:0] RegVal;
  logic [W-1:0] Data_out;
  logic [W-1:0] access_count;

  load_store_unit #(.MEM_DEPTH(DEPTH), .DATA_W(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .Rm(Rm), .Wm(Wm), .address(address), .RegVal(RegVal),
    .Data_out(Data_out), .access_count(access_count)
  );

  always #5 clock = ~clock;

  // Memory: falling-edge write, combinational read while Rm.
  logic [W-1:0] mem [DEPTH];
  always @(negedge clock)
    if (Wm && address < DEPTH) mem[address] <= RegVal;
  assign Data_out = (Rm && address < DEPTH) ? mem[address] : '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: at most one request outstanding.
  logic [W-1:0] mmem [DEPTH];
  bit           model_on = 0;
  bit           pend = 0;
  bit           p_err, p_we;
  int           p_hs, p_vedge;
  logic [W-1:0] p_data;
  logic [W-1:0] n_done = '0;
  logic [W-1:0] offset = '0;
  logic [W-1:0] last_addr = '0;
  logic [W-1:0] last_wdata = '0;
  int           edge_n = 0;

  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      pend = 0;
      n_done = '0;
      last_addr = '0;
      last_wdata = '0;
      model_on = 1;
    end else if (model_on) begin
      if (pend) begin
        if (!p_err && edge_n == p_hs + 1) n_done++;
        if (edge_n > p_vedge && resp_ready) pend = 0;
      end else if (req_valid) begin
        pend   = 1;
        p_hs   = edge_n;
        p_we   = req_we;
        p_err  = (req_addr >= DEPTH);
        p_vedge = p_err ? edge_n : edge_n + 1;
        if (p_err) begin
          p_data = '0;
        end else begin
          last_addr  = req_addr;
          last_wdata = req_wdata;
          if (req_we) begin
            p_data = '0;
            mmem[req_addr] = req_wdata;
          end else begin
            p_data = mmem[req_addr];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    bit ev;
    bit acc;
    if (model_on) begin
      ev  = pend && edge_n >= p_vedge;
      acc = pend && !p_err && edge_n == p_hs;
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("Rm", 32'(Rm), 32'(acc && !p_we));
      chk("Wm", 32'(Wm), 32'(acc && p_we));
      chk("address", 32'(address), 32'(last_addr));
      chk("RegVal", 32'(RegVal), 32'(last_wdata));
      chk("access_count", 32'(access_count),
          32'(W'(n_done + offset)));
      if (ev) begin
        chk("resp_data", 32'(resp_data), 32'(p_data));
        chk("resp_err", 32'(resp_err), 32'(p_err));
      end
    end
  end

  task automatic do_req(input bit we, input logic [W-1:0] a,
                        input logic [W-1:0] d, input int hold,
                        output logic [W-1:0] rd, output bit er,
                        output int lat);
    bit got;
    got = 0;
    lat = -1;
    rd  = '0;
    er  = 0;
    @(posedge clock); #2;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #2;
    req_valid  = 1'b0;
    resp_ready = (hold == 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      resp_ready = 1'b1;
      return;
    end
    rd = resp_data;
    er = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #2;
      if (h == 0) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0003;
        req_wdata = 16'h7777;
      end
      @(negedge clock);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", 32'(resp_data), 32'(rd));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clock); #2;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rd;
    bit           er;
    int           lat;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_count", 32'(access_count), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    do_req(1'b1, 16'h0005, 16'hBEEF, 0, rd, er, lat);
    chk("st5_lat", 32'(lat), 32'd1);
    chk("st5_data", 32'(rd), 32'd0);
    chk("st5_err", 32'(er), 32'd0);
    do_req(1'b0, 16'h0005, 16'h0000, 0, rd, er, lat);
    chk("ld5_data", 32'(rd), 32'h0000BEEF);
    chk("ld5_count", 32'(access_count), 32'd2);

    do_req(1'b0, 16'h0201, 16'h0000, 0, rd, er, lat);
    chk("oor_lat", 32'(lat), 32'd0);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", 32'(rd), 32'd0);
    chk("oor_count", 32'(access_count), 32'd2);

    do_req(1'b1, 16'h0200, 16'h1234, 0, rd, er, lat);
    do_req(1'b0, 16'h0200, 16'h0000, 0, rd, er, lat);
    chk("ld512_data", 32'(rd), 32'h00001234);
    chk("ld512_err", 32'(er), 32'd0);

    do_req(1'b1, 16'hFFFF, 16'h9999, 0, rd, er, lat);
    chk("stffff_err", 32'(er), 32'd1);

    do_req(1'b1, 16'h0007, 16'h5555, 0, rd, er, lat);
    do_req(1'b0, 16'h0007, 16'h0000, 4, rd, er, lat);
    chk("hold_ld_data", 32'(rd), 32'h00005555);

    @(posedge clock); #2;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0010;
    req_wdata = 16'hAAAA;
    @(negedge clock);
    chk("rst_hs_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #2;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    chk("rst_access_wm", 32'(Wm), 32'd1);
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_valid", 32'(resp_valid), 32'd0);
    chk("rst2_wm", 32'(Wm), 32'd0);
    chk("rst2_address", 32'(address), 32'd0);
    chk("rst2_regval", 32'(RegVal), 32'd0);
    chk("rst2_count", 32'(access_count), 32'd0);
    chk("rst2_data", 32'(resp_data), 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("rst2_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 16'h0010, 16'h0000, 0, rd, er, lat);
    chk("ld10_data", 32'(rd), 32'h0000AAAA);

    @(posedge clock); #2;
    force dut.access_count_q = 16'hFFFD;
    #1 release dut.access_count_q;
    offset = 16'hFFFD - n_done;
    do_req(1'b1, 16'h0001, 16'h0101, 0, rd, er, lat);
    chk("wrap_fffe", 32'(access_count), 32'h0000FFFE);
    do_req(1'b1, 16'h0002, 16'h0202, 0, rd, er, lat);
    chk("wrap_ffff", 32'(access_count), 32'h0000FFFF);
    do_req(1'b0, 16'h0001, 16'h0000, 0, rd, er, lat);
    chk("wrap_zero", 32'(access_count), 32'h00000000);
    chk("wrap_ld_data", 32'(rd), 32'h00000101);

    do_req(1'b0, 16'h0000, 16'h0000, 0, rd, er, lat);
    chk("ld0_err", 32'(er), 32'd0);
    do_req(1'b0, 16'h0200, 16'h0000, 0, rd, er, lat);
    chk("ld512b_data", 32'(rd), 32'h00001234);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 513, meaning the number of valid word addresses (0..MEM_DEPTH-1).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the data and address width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the pipeline offers a request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1, with 1 meaning store and 0 meaning load.
REQ-008 The block SHALL have port req_addr, input, DATA_W, meaning the word address.
REQ-009 The block SHALL have port req_wdata, input, DATA_W, meaning the store data.
REQ-010 The block SHALL have port resp_valid, output, 1, meaning a completion is presented.
REQ-011 The block SHALL have port resp_ready, input, 1, meaning the pipeline consumes the completion.
REQ-012 The block SHALL have port resp_data, output, DATA_W, meaning load data (0 for stores and errors).
REQ-013 The block SHALL have port resp_err, output, 1, meaning the address was out of range.
REQ-014 The block SHALL have port Rm, output, 1, the memory read enable.
REQ-015 The block SHALL have port Wm, output, 1, the memory write enable; the memory writes on the falling clock edge.
REQ-016 The block SHALL have port address, output, DATA_W, the memory address.
REQ-017 The block SHALL have port RegVal, output, DATA_W, the memory write data.
REQ-018 The block SHALL have port Data_out, input, DATA_W, the memory read data, combinationally valid while Rm=1.
REQ-019 The block SHALL have port access_count, output, DATA_W, counting completed in-range accesses.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid=1 and req_ready=1.
- Handshake with req_addr < MEM_DEPTH: latch we, addr and wdata, then go to ACCESS.
- Handshake with req_addr >= MEM_DEPTH: go to RESP with resp_err=1 and resp_data=0; Rm and Wm stay 0.
REQ-022 In ACCESS (exactly one cycle), Rm or Wm SHALL be driven from registered outputs per the latched we, and address and RegVal SHALL be driven from the latched values.
- Rm and Wm SHALL never both be 1.
REQ-023 In ACCESS:
- Load: capture Data_out into resp_data at the closing rising edge.
- Store: set resp_data to 0.
- Both: go to RESP and increment access_count, wrapping from 0xFFFF to 0.
REQ-024 In RESP, resp_valid SHALL be 1 and resp_data and resp_err SHALL be held stable until resp_ready=1; on that edge the FSM returns to IDLE.
REQ-025 Latency from handshake edge N:
- In-range access: resp_valid=1 from cycle N+2.
- Error: resp_valid=1 from cycle N+1.
- Minimum throughput: one in-range access per 3 cycles.
REQ-026 Outside ACCESS, Rm and Wm SHALL be 0; address and RegVal SHALL hold their last values.
REQ-027 req_valid during ACCESS or RESP SHALL be ignored (not accepted, no state effect).
REQ-028 Address MEM_DEPTH-1 SHALL be in range; address MEM_DEPTH SHALL be an error.

Reset
REQ-029 On a rising edge with reset=1, the block SHALL set:
- state=IDLE, Rm=0, Wm=0, address=0, RegVal=0;
- resp_valid=0, resp_data=0, resp_err=0, access_count=0.
REQ-030 Reset takes priority over all other events.
- If reset is sampled at the end of an ACCESS store cycle, that store (already committed at the falling edge) SHALL stand.
- No response SHALL be issued for an access in flight at reset.

Structure
REQ-031 The state encoding (IDLE=0, ACCESS=1, RESP=2) and the MEM_DEPTH default SHALL reside in a shared package, mips16_mem_pkg.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Store addr=0x0005 data=0xBEEF, then load 0x0005 -> store resp at N+2 with data 0 and err 0; load resp_data=0xBEEF; access_count=2.
REQ-034 Load addr=0x0201 (513) -> resp_valid at N+1, resp_err=1, resp_data=0, Rm and Wm never 1; access_count unchanged.
REQ-035 Load addr=0x0200 (512) after a store of 0x1234 there -> resp_data=0x1234, resp_err=0.
REQ-036 Hold resp_ready=0 for 4 cycles in RESP -> resp_valid and resp_data stable; req_ready=0; a new req_valid is ignored.
REQ-037 Assert reset in the ACCESS cycle of a store of 0xAAAA to 0x0010 -> outputs clear next edge, no resp_valid; a subsequent load of 0x0010 returns 0xAAAA.
REQ-038 Preload access_count to 0xFFFF via 65535 accesses, then do one more -> access_count=0x0000.
